// File: rtl/sprite_pkg.sv
// sprite_pkg: shared FSM state, screen geometry and play-area limit helpers for the sprite mover.
package sprite_pkg;
  typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;
  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;
  localparam int PAD = 50;
  function automatic int max_x(int h_vis, int obj_w, int pad);
    return h_vis - pad - obj_w;
  endfunction
  function automatic int max_y(int v_vis, int obj_h, int pad);
    return v_vis - pad - obj_h;
  endfunction
endpackage

// File: rtl/sprite_motion_ctrl_if.sv
// sprite_motion_ctrl_if: frame control inputs and published sprite state for the renderer.
interface sprite_motion_ctrl_if #(parameter int SPEED_W = 3);
  logic frame_start, pause;
  logic [SPEED_W-1:0] speed;
  logic [9:0] obj_x, obj_y;
  logic dir_right, dir_down, bounce_x, bounce_y, corner_hit, busy;
  logic [2:0] color_idx;
  modport master(output frame_start, pause, speed,
                 input obj_x, obj_y, dir_right, dir_down, bounce_x, bounce_y, corner_hit, color_idx, busy);
  modport slave(input frame_start, pause, speed,
                output obj_x, obj_y, dir_right, dir_down, bounce_x, bounce_y, corner_hit, color_idx, busy);
endinterface

// File: rtl/axis_stepper.sv
// axis_stepper: one axis of working position, direction and per-frame hit flag with clamped bouncing.
module axis_stepper #(
  parameter int LO = 50,
  parameter int HI = 497,
  parameter int INIT = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       step,
  output logic [9:0] pos,
  output logic       dir,
  output logic       hit
);
  if (INIT < LO || INIT > HI) begin : g_bad_init
    $error("axis_stepper: INIT outside legal range");
  end
  logic [10:0] p;
  logic at_lim;
  assign p = {1'b0, pos};
  assign at_lim = dir ? p >= 11'(HI) : p <= 11'(LO);
  // A step at the limit only reverses, so the position never leaves [LO, HI].
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pos <= 10'(INIT);
      dir <= 1'b1;
      hit <= 1'b0;
    end else begin
      if (clr) hit <= 1'b0;
      if (step && at_lim) begin
        dir <= !dir;
        hit <= 1'b1;
      end else if (step) pos <= dir ? pos + 10'd1 : pos - 10'd1;
    end
endmodule

// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: per-frame scheduler applying speed single-pixel steps and publishing the sprite state.
module sprite_motion_ctrl #(
  parameter int H_VISIBLE = sprite_pkg::H_VISIBLE,
  parameter int V_VISIBLE = sprite_pkg::V_VISIBLE,
  parameter int OBJ_W = 93,
  parameter int OBJ_H = 50,
  parameter int PAD = sprite_pkg::PAD,
  parameter int X_INIT = 50,
  parameter int Y_INIT = 50,
  parameter int SPEED_W = 3
) (
  input logic clk,
  input logic rst_n,
  sprite_motion_ctrl_if.slave bus
);
  import sprite_pkg::*;
  localparam int MAX_X = max_x(H_VISIBLE, OBJ_W, PAD);
  localparam int MAX_Y = max_y(V_VISIBLE, OBJ_H, PAD);
  state_t state;
  logic [SPEED_W-1:0] step_cnt;
  logic accept, step, hit_x, hit_y;
  logic [9:0] work_x, work_y;
  assign accept = state == IDLE && bus.frame_start && !bus.pause && |bus.speed;
  assign step = state == STEP;
  assign bus.busy = state != IDLE;
  axis_stepper #(.LO(PAD), .HI(MAX_X), .INIT(X_INIT)) u_x (
    .clk(clk), .rst_n(rst_n), .clr(accept), .step(step),
    .pos(work_x), .dir(bus.dir_right), .hit(hit_x));
  axis_stepper #(.LO(PAD), .HI(MAX_Y), .INIT(Y_INIT)) u_y (
    .clk(clk), .rst_n(rst_n), .clr(accept), .step(step),
    .pos(work_y), .dir(bus.dir_down), .hit(hit_y));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      step_cnt <= '0;
      bus.obj_x <= 10'(X_INIT);
      bus.obj_y <= 10'(Y_INIT);
      bus.bounce_x <= 1'b0;
      bus.bounce_y <= 1'b0;
      bus.corner_hit <= 1'b0;
      bus.color_idx <= 3'd0;
    end else begin
      bus.bounce_x <= 1'b0;
      bus.bounce_y <= 1'b0;
      bus.corner_hit <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          step_cnt <= bus.speed;
          state <= STEP;
        end
        STEP: begin
          step_cnt <= step_cnt - SPEED_W'(1);
          if (step_cnt == SPEED_W'(1)) state <= DONE;
        end
        DONE: begin
          bus.obj_x <= work_x;
          bus.obj_y <= work_y;
          bus.bounce_x <= hit_x;
          bus.bounce_y <= hit_y;
          bus.corner_hit <= hit_x && hit_y;
          if (hit_x || hit_y) bus.color_idx <= bus.color_idx + 3'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb_sprite_motion_ctrl: directed checks of the sprite scheduler, default geometry and a square-screen variant.
module tb_sprite_motion_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, fs = 1'b0, pz = 1'b0;
  logic [2:0] spd = 3'd0;
  logic abx, aby, ach, bbx, bby, bch;
  int total = 0, bad = 0, bc;
  always #5 clk = ~clk;
  sprite_motion_ctrl_if #(.SPEED_W(3)) ia ();
  sprite_motion_ctrl_if #(.SPEED_W(3)) ib ();
  assign ia.frame_start = fs;
  assign ia.pause = pz;
  assign ia.speed = spd;
  assign ib.frame_start = fs;
  assign ib.pause = pz;
  assign ib.speed = spd;
  sprite_motion_ctrl dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  sprite_motion_ctrl #(.H_VISIBLE(480), .V_VISIBLE(480), .OBJ_W(50), .OBJ_H(50)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib));

  task automatic do_reset();
    rst_n = 1'b0;
    fs = 1'b0;
    pz = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // mode 1 re-pulses frame_start while busy, mode 2 raises pause while busy
  task automatic do_frame(input int mode, output int n);
    @(negedge clk);
    fs = 1'b1;
    @(negedge clk);
    fs = 1'b0;
    n = 0;
    while (ia.busy && n < 50) begin
      n++;
      if (mode == 1) fs = (n == 2);
      if (mode == 2 && n == 2) pz = 1'b1;
      @(negedge clk);
    end
    fs = 1'b0;
    abx = ia.bounce_x; aby = ia.bounce_y; ach = ia.corner_hit;
    bbx = ib.bounce_x; bby = ib.bounce_y; bch = ib.corner_hit;
    pz = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (ia.obj_x !== 10'd50) begin bad++; $display("FAIL reset_obj_x got=%0d exp=50", ia.obj_x); end
    total++; if (ia.obj_y !== 10'd50) begin bad++; $display("FAIL reset_obj_y got=%0d exp=50", ia.obj_y); end
    total++; if ({ia.dir_right, ia.dir_down} !== 2'b11) begin bad++; $display("FAIL reset_dir got=%b exp=11", {ia.dir_right, ia.dir_down}); end
    total++; if (ia.color_idx !== 3'd0) begin bad++; $display("FAIL reset_color got=%0d exp=0", ia.color_idx); end
    total++; if ({ia.busy, ia.bounce_x, ia.bounce_y, ia.corner_hit} !== 4'b0) begin bad++; $display("FAIL reset_busy_pulses got=%b exp=0000", {ia.busy, ia.bounce_x, ia.bounce_y, ia.corner_hit}); end
  endtask

  task automatic test_speed3();
    spd = 3'd3;
    do_frame(0, bc);
    total++; if (bc !== 4) begin bad++; $display("FAIL s3_busy_cycles got=%0d exp=4", bc); end
    total++; if ({ia.obj_x, ia.obj_y} !== {10'd53, 10'd53}) begin bad++; $display("FAIL s3_pos got=%0d,%0d exp=53,53", ia.obj_x, ia.obj_y); end
    total++; if ({abx, aby, ach} !== 3'b0) begin bad++; $display("FAIL s3_pulses got=%b exp=000", {abx, aby, ach}); end
  endtask

  task automatic test_drop_while_busy();
    do_reset();
    spd = 3'd3;
    do_frame(1, bc);
    total++; if (bc !== 4) begin bad++; $display("FAIL drop_busy_cycles got=%0d exp=4", bc); end
    repeat (6) @(negedge clk);
    total++; if (ia.busy !== 1'b0) begin bad++; $display("FAIL drop_busy_after got=%b exp=0", ia.busy); end
    total++; if (ia.obj_x !== 10'd53) begin bad++; $display("FAIL drop_obj_x got=%0d exp=53", ia.obj_x); end
  endtask

  task automatic test_gating();
    spd = 3'd3;
    pz = 1'b1;
    @(negedge clk); fs = 1'b1; @(negedge clk); fs = 1'b0;
    total++; if (ia.busy !== 1'b0) begin bad++; $display("FAIL pause_busy got=%b exp=0", ia.busy); end
    repeat (5) @(negedge clk);
    total++; if ({ia.obj_x, ia.bounce_x, ia.bounce_y} !== {10'd53, 2'b00}) begin bad++; $display("FAIL pause_state got=%0d/%b%b exp=53/00", ia.obj_x, ia.bounce_x, ia.bounce_y); end
    pz = 1'b0;
    spd = 3'd0;
    @(negedge clk); fs = 1'b1; @(negedge clk); fs = 1'b0;
    total++; if (ia.busy !== 1'b0) begin bad++; $display("FAIL speed0_busy got=%b exp=0", ia.busy); end
    repeat (5) @(negedge clk);
    total++; if ({ia.obj_x, ia.obj_y} !== {10'd53, 10'd53}) begin bad++; $display("FAIL speed0_pos got=%0d,%0d exp=53,53", ia.obj_x, ia.obj_y); end
    spd = 3'd3;
    do_frame(2, bc);
    total++; if (bc !== 4) begin bad++; $display("FAIL pause_mid_cycles got=%0d exp=4", bc); end
    total++; if ({ia.obj_x, ia.obj_y} !== {10'd56, 10'd56}) begin bad++; $display("FAIL pause_mid_pos got=%0d,%0d exp=56,56", ia.obj_x, ia.obj_y); end
  endtask

  task automatic test_async_reset();
    spd = 3'd7;
    @(negedge clk); fs = 1'b1; @(negedge clk); fs = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (ia.busy !== 1'b1) begin bad++; $display("FAIL arst_pre_busy got=%b exp=1", ia.busy); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({ia.obj_x, ia.obj_y} !== {10'd50, 10'd50}) begin bad++; $display("FAIL arst_pos got=%0d,%0d exp=50,50", ia.obj_x, ia.obj_y); end
    total++; if ({ia.busy, ia.dir_right, ia.dir_down, ia.color_idx} !== 6'b011000) begin bad++; $display("FAIL arst_flags got=%b exp=011000", {ia.busy, ia.dir_right, ia.dir_down, ia.color_idx}); end
    @(negedge clk);
    rst_n = 1'b1;
    do_frame(0, bc);
    total++; if (bc !== 8) begin bad++; $display("FAIL arst_next_cycles got=%0d exp=8", bc); end
    total++; if ({ia.obj_x, ia.obj_y} !== {10'd57, 10'd57}) begin bad++; $display("FAIL arst_next_pos got=%0d,%0d exp=57,57", ia.obj_x, ia.obj_y); end
  endtask

  task automatic test_long_run();
    do_reset();
    spd = 3'd7;
    for (int f = 1; f <= 64; f++) begin
      do_frame(0, bc);
      total++; if (bc !== 8) begin bad++; $display("FAIL long_cycles frame=%0d got=%0d exp=8", f, bc); end
      if (f == 48) begin
        total++; if ({abx, aby, ach} !== 3'b010) begin bad++; $display("FAIL f48_pulses got=%b exp=010", {abx, aby, ach}); end
        total++; if (ia.obj_y !== 10'd375) begin bad++; $display("FAIL f48_obj_y got=%0d exp=375", ia.obj_y); end
        total++; if ({bbx, bby, bch} !== 3'b111) begin bad++; $display("FAIL corner_pulses got=%b exp=111", {bbx, bby, bch}); end
        total++; if (ib.color_idx !== 3'd1) begin bad++; $display("FAIL corner_color got=%0d exp=1", ib.color_idx); end
        total++; if ({ib.obj_x, ib.obj_y} !== {10'd375, 10'd375}) begin bad++; $display("FAIL corner_pos got=%0d,%0d exp=375,375", ib.obj_x, ib.obj_y); end
      end
      if (f == 64) begin
        total++; if ({abx, aby, ach} !== 3'b100) begin bad++; $display("FAIL f64_pulses got=%b exp=100", {abx, aby, ach}); end
      end
    end
    total++; if ({ia.obj_x, ia.dir_right} !== {10'd497, 1'b0}) begin bad++; $display("FAIL final_x got=%0d/%b exp=497/0", ia.obj_x, ia.dir_right); end
    total++; if ({ia.obj_y, ia.dir_down} !== {10'd263, 1'b0}) begin bad++; $display("FAIL final_y got=%0d/%b exp=263/0", ia.obj_y, ia.dir_down); end
    total++; if (ia.color_idx !== 3'd2) begin bad++; $display("FAIL final_color got=%0d exp=2", ia.color_idx); end
  endtask

  initial begin
    test_reset();
    test_speed3();
    test_drop_while_busy();
    test_gating();
    test_async_reset();
    test_long_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
